// File: rtl/ula_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bundle and FSM states.
package ula_pkg;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpShr  = 3'd2,
    OpShl  = 3'd3,
    OpAnd  = 3'd4,
    OpOr   = 3'd5,
    OpXor  = 3'd6,
    OpPass = 3'd7
  } op_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic neg;
    logic zero;
  } flags_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StShift,
    StDone
  } state_e;

  // Shifts run on the serial shifter; everything else goes through ula_core.
  function automatic logic is_shift(op_e op);
    return (op == OpShr) || (op == OpShl);
  endfunction

endpackage

// File: rtl/ula_core.sv
// Combinational ALU core: ADD/SUB/logic/PASS with result flags. Shifts are handled
// by the serial shifter in ula_seq; for shift opcodes this core simply passes a through.
module ula_core
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // diff[WIDTH] is set exactly when a < b unsigned, i.e. the borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  // Select the result for the opcode and derive carry/overflow, then neg/zero from the result.
  always_comb begin
    result = a;
    flags  = '0;
    unique case (op)
      OpAdd: begin
        result      = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        result      = diff[WIDTH-1:0];
        flags.carry = diff[WIDTH];
        flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpPass:  result = b;
      default: result = a;
    endcase
    flags.neg  = result[WIDTH-1];
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU: valid/ready operand and result handshakes, accumulator, flag register
// and a 1-bit-per-cycle serial shifter around the combinational ula_core.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_s,
  output flags_t           flags
);

  localparam int unsigned SHW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  op_e              op_in, op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, a_sel;
  logic [SHW-1:0]   cnt_q, shamt, k;
  logic             carry_q;
  logic             accept;
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags, shift_flags;

  assign op_in  = op_e'(op);
  assign a_sel  = use_acc ? acc_q : input_a;
  assign shamt  = input_b[SHW-1:0];
  // Shifting further than WIDTH gives the same result as shifting by WIDTH.
  assign k      = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;

  assign shift_flags = '{carry: carry_q, ovf: 1'b0, neg: a_q[WIDTH-1], zero: (a_q == '0)};

  ula_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .result(core_res),
    .flags (core_flags)
  );

  // Handshake outputs and next-state selection.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    accept    = in_valid && in_ready;
    unique case (state_q)
      StIdle:  if (accept) state_d = is_shift(op_in) ? StShift : StExec;
      StExec:  state_d = StDone;
      StShift: if (cnt_q == '0) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, serial shifter, result/flag registers and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      output_s <= '0;
      flags    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= op_in;
            a_q     <= a_sel;
            b_q     <= input_b;
            cnt_q   <= k;
            carry_q <= 1'b0;
          end
        end
        StExec: begin
          output_s <= core_res;
          flags    <= core_flags;
        end
        StShift: begin
          // a_q doubles as the shift register; the final cycle only publishes it.
          if (cnt_q != '0) begin
            if (op_q == OpShl) begin
              carry_q <= a_q[WIDTH-1];
              a_q     <= {a_q[WIDTH-2:0], 1'b0};
            end else begin
              carry_q <= a_q[0];
              a_q     <= {1'b0, a_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q - SHW'(1);
          end else begin
            output_s <= a_q;
            flags    <= shift_flags;
          end
        end
        StDone: begin
          if (out_ready) acc_q <= output_s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq (WIDTH=4): a driver pushes model expectations on accept,
// a monitor compares every cycle a result is presented and pops on retirement.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int W = 4;
  localparam int M = 1 << W;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
    longint       acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic         use_acc = 1'b0;
  logic [W-1:0] input_a = '0;
  logic [W-1:0] input_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] output_s;
  flags_t       flags;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     acc_m = 0;
  int     stall_left = 0;
  bit     seen = 0;

  ula_seq #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .use_acc  (use_acc),
    .input_a  (input_a),
    .input_b  (input_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .output_s (output_s),
    .flags    (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Reference model written from the arithmetic rules, in plain integers.
  function automatic exp_t model(int o, int a, int b);
    exp_t e;
    int r, c, v, k, s;
    c = 0; v = 0; r = 0;
    k = b % (2 * W);
    if (k > W) k = W;
    e.lat = 1;
    case (o)
      0: begin
        r = (a + b) % M; c = (a + b >= M); s = sgn(a) + sgn(b);
        v = (s > M / 2 - 1) || (s < -M / 2);
      end
      1: begin
        r = (a - b + M) % M; c = (a < b); s = sgn(a) - sgn(b);
        v = (s > M / 2 - 1) || (s < -M / 2);
      end
      2: begin
        r = a >> k; c = (k == 0) ? 0 : (a >> (k - 1)) & 1; e.lat = 1 + k;
      end
      3: begin
        r = (a << k) % M; c = (k == 0) ? 0 : (a >> (W - k)) & 1; e.lat = 1 + k;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = b;
    endcase
    e.res = W'(r);
    e.flg = {c[0], v[0], (r >= M / 2), (r == 0)};
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic issue(input int o, input bit ua, input int a, input int b);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    in_valid = 1'b1; op = 3'(o); use_acc = ua; input_a = W'(a); input_b = W'(b);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_timeout", longint'(in_ready), 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    e = model(o, ua ? acc_m : a, b);
    e.acc_cyc = cyc + 1;
    acc_m = int'(e.res);
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_output_s", longint'(output_s), 0);
    chk("rst_flags", longint'(flags), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    sb.delete();
    seen = 0; acc_m = 0; stall_left = 0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare whenever a result is presented, drive out_ready, pop on retirement.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", longint'(out_valid), 0);
          out_ready = 1'b1;
        end else begin
          e = sb[0];
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - e.acc_cyc, e.lat);
          end
          chk("output_s", longint'(output_s), longint'(e.res));
          chk("flags", longint'(flags), longint'(e.flg));
          chk("in_ready_busy", longint'(in_ready), 0);
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = ($urandom_range(0, 3) != 0);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #3;
    apply_reset();
    // Arithmetic corners
    issue(0, 0, 7, 1);
    issue(1, 0, 3, 5);
    issue(1, 0, 5, 5);
    // Serial shifts, including a capped shift amount
    issue(3, 0, 4'b0011, 2);
    issue(2, 0, 4'b0101, 1);
    issue(2, 0, 4'b1011, 7);
    issue(3, 0, 4'b1001, 0);
    wait_drain();
    // Backpressure with a second beat pending
    issue(6, 0, 4'hA, 4'h3);
    stall_left = 5;
    issue(5, 0, 4'h1, 4'h8);
    wait_drain();
    // Accumulate from reset
    apply_reset();
    for (int i = 0; i < 3; i++) issue(0, 1, int'($urandom_range(0, M - 1)), 3);
    issue(1, 1, int'($urandom_range(0, M - 1)), 9);
    wait_drain();
    // Reset one cycle into a shift
    issue(3, 0, 4'b0111, 3);
    @(posedge clk);
    #2;
    apply_reset();
    issue(0, 0, 1, 1);
    wait_drain();
    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      issue(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)));
    end
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
